// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-stage access unit: funct3 encodings,
// the load result-source code and the access FSM state type.
package mem_access_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Access size lives in funct3[1:0]: 00 byte, 01 half, anything else word.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            2'b00:   return 4'b0001 << addr_lo;
            2'b01:   return addr_lo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_load_extend.sv
// Load lane select and sign/zero extension of a read word, keyed by the low
// address bits and funct3; unknown funct3 codes return the full word.
module load_extend
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] ext
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    function automatic logic [31:0] sext8(input logic signed [7:0] b);
        logic signed [31:0] s;
        s = b;
        return s;
    endfunction

    function automatic logic [31:0] sext16(input logic signed [15:0] h);
        logic signed [31:0] s;
        s = h;
        return s;
    endfunction

    always_comb begin
        case (addr_lo)
            2'b00:   byte_sel = word[7:0];
            2'b01:   byte_sel = word[15:8];
            2'b10:   byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        case (funct3)
            F3_LB:   ext = sext8(byte_sel);
            F3_LH:   ext = sext16(half_sel);
            F3_LBU:  ext = {24'd0, byte_sel};
            F3_LHU:  ext = {16'd0, half_sel};
            F3_LW:   ext = word;
            default: ext = word;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-stage data access unit: single-outstanding req/ack data port with stall.
// Optional macro MISALIGN_TRAP_EN turns misaligned half/word accesses into a trap flag.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] i_alu_result_M,
    input  logic [DATA_WIDTH-1:0] i_write_data_M,
    input  logic                  i_mem_write_M,
    input  logic [1:0]            i_result_src_M,
    input  logic [2:0]            i_funct3_M,
    output logic [DATA_WIDTH-1:0] o_read_data_M,
    output logic                  o_stall_M,
    output logic                  o_misaligned_M,
    output logic                  o_dmem_req,
    output logic                  o_dmem_we,
    output logic [DATA_WIDTH-1:0] o_dmem_addr,
    output logic [DATA_WIDTH-1:0] o_dmem_wdata,
    output logic [3:0]            o_dmem_be,
    input  logic                  i_dmem_ack,
    input  logic [DATA_WIDTH-1:0] i_dmem_rdata
);

    state_t                state, state_nxt;
    logic                  is_store, is_load, access, misaligned, req_raw;
    logic [DATA_WIDTH-1:0] load_ext;

    assign is_store = i_mem_write_M;
    assign is_load  = !i_mem_write_M && (i_result_src_M == RESULT_SRC_MEM);
    assign access   = is_store || is_load;

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        case (i_funct3_M[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = access && i_alu_result_M[0];
            default: misaligned = access && (i_alu_result_M[1:0] != 2'b00);
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        req_raw   = 1'b0;
        case (state)
            IDLE: begin
                if (access && !misaligned) begin
                    req_raw   = 1'b1;
                    state_nxt = i_dmem_ack ? DONE : BUSY;
                end
            end
            BUSY: begin
                req_raw = 1'b1;
                if (i_dmem_ack) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Reset kills an in-flight request in the same cycle; memory must cope.
    assign o_dmem_req     = req_raw && !rst;
    assign o_stall_M      = req_raw && !rst;
    assign o_dmem_we      = o_dmem_req && is_store;
    assign o_misaligned_M = misaligned && (state == IDLE) && !rst;
    assign o_dmem_addr    = {i_alu_result_M[DATA_WIDTH-1:2], 2'b00};
    assign o_dmem_be      = byte_enable(i_funct3_M[1:0], i_alu_result_M[1:0]);

    always_comb begin
        case (i_funct3_M)
            F3_SB:   o_dmem_wdata = {4{i_write_data_M[7:0]}};
            F3_SH:   o_dmem_wdata = {2{i_write_data_M[15:0]}};
            F3_SW:   o_dmem_wdata = i_write_data_M;
            default: o_dmem_wdata = i_write_data_M;
        endcase
    end

    load_extend u_load_extend (
        .word    (i_dmem_rdata),
        .addr_lo (i_alu_result_M[1:0]),
        .funct3  (i_funct3_M),
        .ext     (load_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            o_read_data_M <= '0;
        end else begin
            state <= state_nxt;
            if (o_dmem_req && i_dmem_ack && is_load) o_read_data_M <= load_ext;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a table of single-access vectors plus
// hand sequences for wait states, reset during an access and misalignment.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result, write_data, dmem_rdata;
    logic        mem_write, dmem_ack;
    logic [1:0]  result_src;
    logic [2:0]  funct3;
    logic [31:0] read_data, dmem_addr, dmem_wdata;
    logic        stall, misaligned, dmem_req, dmem_we;
    logic [3:0]  dmem_be;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access #(.DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_alu_result_M (alu_result),
        .i_write_data_M (write_data),
        .i_mem_write_M  (mem_write),
        .i_result_src_M (result_src),
        .i_funct3_M     (funct3),
        .o_read_data_M  (read_data),
        .o_stall_M      (stall),
        .o_misaligned_M (misaligned),
        .o_dmem_req     (dmem_req),
        .o_dmem_we      (dmem_we),
        .o_dmem_addr    (dmem_addr),
        .o_dmem_wdata   (dmem_wdata),
        .o_dmem_be      (dmem_be),
        .i_dmem_ack     (dmem_ack),
        .i_dmem_rdata   (dmem_rdata)
    );

    typedef struct {
        string       name;
        logic        mw;
        logic [1:0]  rsrc;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        exp_req;
        logic        exp_we;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_write  = 1'b0;
        result_src = 2'b00;
        funct3     = 3'b000;
        alu_result = 32'h0;
        write_data = 32'h0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
    endtask

    task automatic set_vec(input vec_t v);
        mem_write  = v.mw;
        result_src = v.rsrc;
        funct3     = v.f3;
        alu_result = v.addr;
        write_data = v.wd;
        dmem_rdata = v.rdata;
    endtask

    initial begin
        //                name    mw  rsrc   f3      addr          wd            rdata         req we be       exp_addr      exp_wdata     exp_rd
        vecs[0]  = '{"lhu",   0, 2'b01, 3'b101, 32'h0000_0102, 32'h0,        32'h8001_FFFF, 1, 0, 4'b1100, 32'h0000_0100, 32'h0,         32'h0000_8001};
        vecs[1]  = '{"sw",    1, 2'b00, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1, 1, 4'b1111, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_8001};
        vecs[2]  = '{"lh",    0, 2'b01, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_FFFF, 1, 0, 4'b1100, 32'h0000_0100, 32'h0,         32'hFFFF_8001};
        vecs[3]  = '{"sb",    1, 2'b00, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,        1, 1, 4'b1000, 32'h0000_0100, 32'hA5A5_A5A5, 32'hFFFF_8001};
        vecs[4]  = '{"sh",    1, 2'b00, 3'b001, 32'h0000_0102, 32'h1234_BEEF, 32'h0,        1, 1, 4'b1100, 32'h0000_0100, 32'hBEEF_BEEF, 32'hFFFF_8001};
        vecs[5]  = '{"lbu",   0, 2'b01, 3'b100, 32'h0000_0101, 32'h0,        32'h1280_5634, 1, 0, 4'b0010, 32'h0000_0100, 32'h0,         32'h0000_0056};
        vecs[6]  = '{"lb",    0, 2'b01, 3'b000, 32'h0000_0103, 32'h0,        32'h8000_0000, 1, 0, 4'b1000, 32'h0000_0100, 32'h0,         32'hFFFF_FF80};
        vecs[7]  = '{"lw",    0, 2'b01, 3'b010, 32'h0000_0104, 32'h0,        32'hCAFE_F00D, 1, 0, 4'b1111, 32'h0000_0104, 32'h0,         32'hCAFE_F00D};
        vecs[8]  = '{"l011",  0, 2'b01, 3'b011, 32'h0000_0108, 32'h0,        32'h1122_3344, 1, 0, 4'b1111, 32'h0000_0108, 32'h0,         32'h1122_3344};
        vecs[9]  = '{"both",  1, 2'b01, 3'b010, 32'h0000_010C, 32'h0BAD_F00D, 32'hFFFF_FFFF, 1, 1, 4'b1111, 32'h0000_010C, 32'h0BAD_F00D, 32'h1122_3344};
        vecs[10] = '{"none",  0, 2'b00, 3'b010, 32'h0000_0110, 32'h0,        32'h9999_9999, 0, 0, 4'b1111, 32'h0000_0110, 32'h0,         32'h1122_3344};
        vecs[11] = '{"rs10",  0, 2'b10, 3'b010, 32'h0000_0114, 32'h0,        32'h7777_7777, 0, 0, 4'b1111, 32'h0000_0114, 32'h0,         32'h1122_3344};
        vecs[12] = '{"lhpos", 0, 2'b01, 3'b001, 32'h0000_0100, 32'h0,        32'h0000_7FFF, 1, 0, 4'b0011, 32'h0000_0100, 32'h0,         32'h0000_7FFF};
        vecs[13] = '{"sb1",   1, 2'b00, 3'b000, 32'h0000_0101, 32'h1234_5678, 32'h0,        1, 1, 4'b0010, 32'h0000_0100, 32'h7878_7878, 32'h0000_7FFF};

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-wait-state table: ack is offered in the request cycle.
        for (int i = 0; i < 14; i++) begin
            set_vec(vecs[i]);
            dmem_ack = 1'b1;
            #1;
            chk({vecs[i].name, "_req"}, {31'd0, dmem_req}, {31'd0, vecs[i].exp_req});
            chk({vecs[i].name, "_stall"}, {31'd0, stall}, {31'd0, vecs[i].exp_req});
            if (vecs[i].exp_req) begin
                chk({vecs[i].name, "_we"}, {31'd0, dmem_we}, {31'd0, vecs[i].exp_we});
                chk({vecs[i].name, "_be"}, {28'd0, dmem_be}, {28'd0, vecs[i].exp_be});
                chk({vecs[i].name, "_addr"}, dmem_addr, vecs[i].exp_addr);
                chk({vecs[i].name, "_wdata"}, dmem_wdata, vecs[i].exp_wdata);
            end
            @(negedge clk);
            chk({vecs[i].name, "_done_stall"}, {31'd0, stall}, 32'd0);
            chk({vecs[i].name, "_done_req"}, {31'd0, dmem_req}, 32'd0);
            chk({vecs[i].name, "_read_data"}, read_data, vecs[i].exp_rd);
            idle_inputs();
            @(negedge clk);
        end

        // LB with two wait states: three stall cycles, address held throughout.
        begin
            int stalls;
            mem_write  = 1'b0;
            result_src = 2'b01;
            funct3     = 3'b000;
            alu_result = 32'h0000_0102;
            dmem_rdata = 32'h1280_5634;
            dmem_ack   = 1'b0;
            stalls     = 0;
            for (int c = 0; c < 10; c++) begin
                #1;
                if (!stall) break;
                stalls++;
                chk("wait_addr", dmem_addr, 32'h0000_0100);
                chk("wait_be", {28'd0, dmem_be}, 32'h0000_0004);
                chk("wait_req", {31'd0, dmem_req}, 32'd1);
                dmem_ack = (stalls == 3);
                @(negedge clk);
            end
            chk("wait_stall_cycles", stalls, 32'd3);
            chk("wait_read_data", read_data, 32'hFFFF_FF80);
            idle_inputs();
            @(negedge clk);
        end

        // Ack while idle must not touch the load register.
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5A5A_5A5A;
        #1;
        chk("stray_ack_req", {31'd0, dmem_req}, 32'd0);
        @(negedge clk);
        chk("stray_ack_read_data", read_data, 32'hFFFF_FF80);
        idle_inputs();
        @(negedge clk);

        // Reset while BUSY: request and stall fall in the reset cycle itself.
        mem_write  = 1'b0;
        result_src = 2'b01;
        funct3     = 3'b010;
        alu_result = 32'h0000_0200;
        dmem_rdata = 32'h1357_9BDF;
        #1;
        chk("busy_req_before", {31'd0, dmem_req}, 32'd1);
        @(negedge clk);
        chk("busy_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_busy_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_busy_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h2468_ACE0;
        #1;
        chk("post_rst_req", {31'd0, dmem_req}, 32'd0);
        chk("post_rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        chk("post_rst_read_data", read_data, 32'h0);
        idle_inputs();
        @(negedge clk);

        // Misaligned LW at 0x101.
        mem_write  = 1'b0;
        result_src = 2'b01;
        funct3     = 3'b010;
        alu_result = 32'h0000_0101;
        dmem_rdata = 32'hA1B2_C3D4;
        dmem_ack   = 1'b1;
        #1;
`ifdef MISALIGN_TRAP_EN
        chk("mis_req", {31'd0, dmem_req}, 32'd0);
        chk("mis_stall", {31'd0, stall}, 32'd0);
        chk("mis_flag", {31'd0, misaligned}, 32'd1);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("mis_flag_drop", {31'd0, misaligned}, 32'd0);
        chk("mis_read_data", read_data, 32'h0);
`else
        chk("mis_req", {31'd0, dmem_req}, 32'd1);
        chk("mis_flag", {31'd0, misaligned}, 32'd0);
        chk("mis_addr", dmem_addr, 32'h0000_0100);
        chk("mis_be", {28'd0, dmem_be}, 32'h0000_000F);
        @(negedge clk);
        chk("mis_read_data", read_data, 32'hA1B2_C3D4);
        idle_inputs();
`endif
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
